// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the ALU: decodes one MIPS-I instruction per accept
// and presents the operand bundle through a 2-entry skid buffer.
module alu_issue_stage #(
  parameter int          DEPTH         = 2,
  parameter logic [5:0]  ILLEGAL_ACODE = 6'b100001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [5:0]  out_aluc,
  output logic [4:0]  out_dst,
  output logic        out_wen,
  output logic        out_illegal,
  output logic [15:0] issue_cnt
);

  if (DEPTH != 2) begin : g_depth_check
    $error("alu_issue_stage: DEPTH must be 2");
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  aluc;
    logic [4:0]  dst;
    logic        wen;
    logic        illegal;
  } bundle_t;

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext;
  logic        unused_rs_field;
  logic        illegal;
  bundle_t     dec;

  assign op       = in_instr[31:26];
  assign rt       = in_instr[20:16];
  assign rd       = in_instr[15:11];
  assign shamt    = in_instr[10:6];
  assign funct    = in_instr[5:0];
  assign imm      = in_instr[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  // rs arrives pre-read as in_rs_val, so the field itself is not needed here.
  assign unused_rs_field = ^in_instr[25:21];

  always_comb begin
    illegal      = 1'b0;
    dec.a        = in_rs_val;
    dec.b        = imm_sext;
    dec.aluc     = ILLEGAL_ACODE;
    dec.dst      = rt;
    dec.wen      = 1'b1;
    dec.illegal  = 1'b0;
    case (op)
      6'b000000: begin
        dec.aluc = funct;
        dec.b    = in_rt_val;
        dec.dst  = rd;
        case (funct)
          6'b000000, 6'b000010, 6'b000011: dec.a = {27'd0, shamt};
          6'b000100, 6'b000110, 6'b000111,
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011:            dec.wen = 1'b1;
          6'b001000:                       dec.wen = 1'b0;
          default:                         illegal = 1'b1;
        endcase
      end
      6'b001000: dec.aluc = 6'b100000;
      6'b001001: dec.aluc = 6'b100001;
      6'b001010: dec.aluc = 6'b101010;
      6'b001011: dec.aluc = 6'b101011;
      6'b001100: begin dec.aluc = 6'b100100; dec.b = imm_zext; end
      6'b001101: begin dec.aluc = 6'b100101; dec.b = imm_zext; end
      6'b001110: begin dec.aluc = 6'b100110; dec.b = imm_zext; end
      6'b001111: begin dec.aluc = 6'b001111; dec.a = imm_zext; dec.b = 32'd0; end
      6'b100011: dec.aluc = 6'b100001;
      6'b101011: begin dec.aluc = 6'b100001; dec.wen = 1'b0; dec.dst = 5'd0; end
      6'b000100, 6'b000101: begin
        dec.aluc = 6'b100011;
        dec.b    = in_rt_val;
        dec.wen  = 1'b0;
        dec.dst  = 5'd0;
      end
      default: illegal = 1'b1;
    endcase
    // Undecodable words still travel down the pipe, but as an inert ADDU 0,0.
    if (illegal) begin
      dec.a       = 32'd0;
      dec.b       = 32'd0;
      dec.aluc    = ILLEGAL_ACODE;
      dec.dst     = 5'd0;
      dec.wen     = 1'b0;
      dec.illegal = 1'b1;
    end else begin
      dec.illegal = 1'b0;
    end
  end

  bundle_t     e0_q, e1_q;
  logic        e0_valid_q, e1_valid_q, ready_q;
  logic [15:0] cnt_q;
  logic        accept, drain;

  assign accept = in_valid && ready_q;
  assign drain  = e0_valid_q && out_ready;

  // Entry0 feeds the outputs; entry1 only fills when entry0 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q       <= '0;
      e1_q       <= '0;
      e0_valid_q <= 1'b0;
      e1_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      cnt_q      <= 16'd0;
    end else if (flush) begin
      e0_q       <= '0;
      e1_q       <= '0;
      e0_valid_q <= 1'b0;
      e1_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      cnt_q      <= 16'd0;
    end else begin
      if (drain) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (e1_valid_q) begin
        if (drain) begin
          e0_q       <= e1_q;
          e1_q       <= '0;
          e1_valid_q <= 1'b0;
          ready_q    <= 1'b1;
        end
      end else if (accept) begin
        if (!e0_valid_q || drain) begin
          e0_q       <= dec;
          e0_valid_q <= 1'b1;
        end else begin
          e1_q       <= dec;
          e1_valid_q <= 1'b1;
          ready_q    <= 1'b0;
        end
      end else if (drain) begin
        e0_q       <= '0;
        e0_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = e0_valid_q;
  assign out_a       = e0_q.a;
  assign out_b       = e0_q.b;
  assign out_aluc    = e0_q.aluc;
  assign out_dst     = e0_q.dst;
  assign out_wen     = e0_q.wen;
  assign out_illegal = e0_q.illegal;
  assign issue_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus handshake,
// flush and reset sequences.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_rs_val, in_rt_val, out_a, out_b;
  logic [5:0]  out_aluc;
  logic [4:0]  out_dst;
  logic        out_wen, out_illegal;
  logic [15:0] issue_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_aluc(out_aluc),
    .out_dst(out_dst), .out_wen(out_wen), .out_illegal(out_illegal),
    .issue_cnt(issue_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  aluc;
    logic [4:0]  dst;
    logic        wen;
    logic        ill;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt);
    in_valid  = v;
    in_instr  = ins;
    in_rs_val = rs;
    in_rt_val = rt;
  endtask

  initial begin
    vecs[0]  = '{32'h2109FFFC, 32'h00000010, 32'h0, 32'h00000010, 32'hFFFFFFFC, 6'b100000, 5'd9,  1'b1, 1'b0};
    vecs[1]  = '{32'h000B5143, 32'h12345678, 32'h80000000, 32'h5, 32'h80000000, 6'b000011, 5'd10, 1'b1, 1'b0};
    vecs[2]  = '{32'h34228001, 32'h12340000, 32'h0, 32'h12340000, 32'h00008001, 6'b100101, 5'd2,  1'b1, 1'b0};
    vecs[3]  = '{32'h3C038001, 32'hDEADBEEF, 32'h0, 32'h00008001, 32'h00000000, 6'b001111, 5'd3,  1'b1, 1'b0};
    vecs[4]  = '{32'hFC000000, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 6'b100001, 5'd0, 1'b0, 1'b1};
    vecs[5]  = '{32'h03E00008, 32'h00000400, 32'h00000055, 32'h00000400, 32'h00000055, 6'b001000, 5'd0, 1'b0, 1'b0};
    vecs[6]  = '{32'hAFA8FFF8, 32'h7FFF0000, 32'h0, 32'h7FFF0000, 32'hFFFFFFF8, 6'b100001, 5'd0, 1'b0, 1'b0};
    vecs[7]  = '{32'h8D090004, 32'h00001000, 32'h0, 32'h00001000, 32'h00000004, 6'b100001, 5'd9, 1'b1, 1'b0};
    vecs[8]  = '{32'h11090010, 32'h00000007, 32'h00000009, 32'h7, 32'h9, 6'b100011, 5'd0, 1'b0, 1'b0};
    vecs[9]  = '{32'h3022F0F0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0000F0F0, 6'b100100, 5'd2, 1'b1, 1'b0};
    vecs[10] = '{32'h2C22FFFF, 32'h00000003, 32'h0, 32'h3, 32'hFFFFFFFF, 6'b101011, 5'd2, 1'b1, 1'b0};
    vecs[11] = '{32'h00221821, 32'hA0000000, 32'h0000000B, 32'hA0000000, 32'h0000000B, 6'b100001, 5'd3, 1'b1, 1'b0};
    vecs[12] = '{32'h0000000F, 32'h33333333, 32'h44444444, 32'h0, 32'h0, 6'b100001, 5'd0, 1'b0, 1'b1};
    vecs[13] = '{32'h00021FC0, 32'h55555555, 32'h00000001, 32'd31, 32'h1, 6'b000000, 5'd3, 1'b1, 1'b0};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #12;
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_a", out_a, 32'h0);
    check("rst.issue_cnt", issue_cnt, 16'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk) drive(1'b1, vecs[i].instr, vecs[i].rs, vecs[i].rt);
      @(negedge clk) in_valid = 1'b0;
      check($sformatf("v%0d.valid", i), out_valid, 1'b1);
      check($sformatf("v%0d.a", i), out_a, vecs[i].a);
      check($sformatf("v%0d.b", i), out_b, vecs[i].b);
      check($sformatf("v%0d.aluc", i), out_aluc, vecs[i].aluc);
      check($sformatf("v%0d.dst", i), out_dst, vecs[i].dst);
      check($sformatf("v%0d.wen", i), out_wen, vecs[i].wen);
      check($sformatf("v%0d.ill", i), out_illegal, vecs[i].ill);
    end
    @(negedge clk);
    check("table.issue_cnt", issue_cnt, 16'd14);
    check("table.out_valid", out_valid, 1'b0);

    // Backpressure: two accepted, third refused, then FIFO drain.
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    check("flush0.issue_cnt", issue_cnt, 16'd0);
    out_ready = 1'b0;
    drive(1'b1, vecs[0].instr, vecs[0].rs, vecs[0].rt);
    @(negedge clk);
    check("bp.ready_after1", in_ready, 1'b1);
    drive(1'b1, vecs[1].instr, vecs[1].rs, vecs[1].rt);
    @(negedge clk);
    check("bp.ready_after2", in_ready, 1'b0);
    drive(1'b1, vecs[2].instr, vecs[2].rs, vecs[2].rt);
    @(negedge clk);
    check("bp.ready_hold", in_ready, 1'b0);
    check("bp.hold_a", out_a, 32'h00000010);
    check("bp.hold_aluc", out_aluc, 6'b100000);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp.ready_rise", in_ready, 1'b1);
    check("bp.second_aluc", out_aluc, 6'b000011);
    check("bp.second_a", out_a, 32'h5);
    check("bp.cnt1", issue_cnt, 16'd1);
    @(negedge clk);
    check("bp.empty", out_valid, 1'b0);
    check("bp.cnt2", issue_cnt, 16'd2);

    // Flush with the buffer full and an accept presented.
    out_ready = 1'b0;
    drive(1'b1, vecs[7].instr, vecs[7].rs, vecs[7].rt);
    @(negedge clk) drive(1'b1, vecs[9].instr, vecs[9].rs, vecs[9].rt);
    @(negedge clk);
    check("fl.full", in_ready, 1'b0);
    flush = 1'b1;
    drive(1'b1, vecs[10].instr, vecs[10].rs, vecs[10].rt);
    @(negedge clk) flush = 1'b0; in_valid = 1'b0;
    check("fl.out_valid", out_valid, 1'b0);
    check("fl.in_ready", in_ready, 1'b1);
    check("fl.issue_cnt", issue_cnt, 16'd0);
    @(negedge clk);
    check("fl.no_stale", out_valid, 1'b0);

    // Flush while entry0 is held and in_ready is still high.
    drive(1'b1, vecs[7].instr, vecs[7].rs, vecs[7].rt);
    @(negedge clk) flush = 1'b1;
    drive(1'b1, vecs[9].instr, vecs[9].rs, vecs[9].rt);
    @(negedge clk) flush = 1'b0; in_valid = 1'b0;
    check("fl2.out_valid", out_valid, 1'b0);
    check("fl2.in_ready", in_ready, 1'b1);

    // Asynchronous reset with a bundle held at the output.
    out_ready = 1'b1;
    @(negedge clk) drive(1'b1, vecs[11].instr, vecs[11].rs, vecs[11].rt);
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk);
    check("ar.cnt_before", issue_cnt, 16'd1);
    out_ready = 1'b0;
    drive(1'b1, vecs[2].instr, vecs[2].rs, vecs[2].rt);
    @(negedge clk) in_valid = 1'b0;
    check("ar.held", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("ar.out_valid", out_valid, 1'b0);
    check("ar.out_a", out_a, 32'h0);
    check("ar.out_b", out_b, 32'h0);
    check("ar.out_aluc", out_aluc, 6'h0);
    check("ar.out_dst", out_dst, 5'h0);
    check("ar.in_ready", in_ready, 1'b1);
    check("ar.issue_cnt", issue_cnt, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("ar.after_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
